// File: rtl/spin_ctrl_if.sv
// Board-side control inputs and decoder-side outputs of the spinner sequencer.
// Latency: none (signal bundle only).
// Backpressure: none; outputs are level/pulse signals with no handshake.
interface spin_ctrl_if;
  logic       en_i;
  logic       dir_i;
  logic [1:0] speed_i;
  logic       step_i;
  logic       blank_i;
  logic [2:0] pos_o;
  logic       tick_o;
  logic       running_o;

  // Board side: drives the switches/buttons and observes the position
  modport master (
    output en_i, dir_i, speed_i, step_i, blank_i,
    input  pos_o, tick_o, running_o
  );

  // Sequencer side
  modport slave (
    input  en_i, dir_i, speed_i, step_i, blank_i,
    output pos_o, tick_o, running_o
  );
endinterface

// File: rtl/spin_ctrl.sv
// Spinner sequencer: prescaled run/stop position stepping, single-step, blanking.
// Latency: 1 cycle from any sampled input to pos_o/tick_o/running_o.
// Backpressure: none; the decoder consumes pos_o every cycle.
module spin_ctrl #(
  parameter int unsigned BASE_DIV = 24'd6_000_000,
  parameter int unsigned DIV_W    = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  spin_ctrl_if.slave  bus
);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  // Reload values are period-1 for each speed; truncating shifts keep period >= 1
  localparam logic [DIV_W-1:0] RELOAD_S0 = DIV_W'(BASE_DIV - 1);
  localparam logic [DIV_W-1:0] RELOAD_S1 = DIV_W'((BASE_DIV >> 1) - 1);
  localparam logic [DIV_W-1:0] RELOAD_S2 = DIV_W'((BASE_DIV >> 2) - 1);
  localparam logic [DIV_W-1:0] RELOAD_S3 = DIV_W'((BASE_DIV >> 3) - 1);

  state_t           state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic [2:0]       pos_r, pos_nx;
  logic             tick_r, tick_nx;
  logic             step_q;
  logic             blank_q;
  logic [DIV_W-1:0] reload;
  logic [2:0]       pos_adv;

  // Reload value selected from the speed present on the reloading edge
  always_comb begin
    reload = RELOAD_S0;
    case (bus.speed_i)
      2'd0:    reload = RELOAD_S0;
      2'd1:    reload = RELOAD_S1;
      2'd2:    reload = RELOAD_S2;
      default: reload = RELOAD_S3;
    endcase
  end

  // Next position in the requested direction, wrapping within 0..5
  always_comb begin
    pos_adv = pos_r;
    if (bus.dir_i) begin
      pos_adv = (pos_r == 3'd0) ? 3'd5 : pos_r - 3'd1;
    end else begin
      pos_adv = (pos_r == 3'd5) ? 3'd0 : pos_r + 3'd1;
    end
  end

  // Run/stop next-state, prescaler and advance decisions
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pos_nx   = pos_r;
    tick_nx  = 1'b0;
    case (state)
      STOP: begin
        if (bus.en_i) begin
          // Starting edge swallows any coincident step edge
          state_nx = RUN;
          cnt_nx   = reload;
        end else if (bus.step_i && !step_q) begin
          pos_nx  = pos_adv;
          tick_nx = 1'b1;
        end
      end
      RUN: begin
        if (!bus.en_i) begin
          // Stopping wins over an expiring count on the same edge
          state_nx = STOP;
        end else if (cnt == '0) begin
          pos_nx  = pos_adv;
          tick_nx = 1'b1;
          cnt_nx  = reload;
        end else begin
          cnt_nx = cnt - DIV_W'(1);
        end
      end
      default: state_nx = STOP;
    endcase
  end

  // State register; step_q resets high so a button held through reset is not a step
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= STOP;
      cnt     <= '0;
      pos_r   <= 3'd0;
      tick_r  <= 1'b0;
      step_q  <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pos_r   <= pos_nx;
      tick_r  <= tick_nx;
      step_q  <= bus.step_i;
      blank_q <= bus.blank_i;
    end
  end

  // Blanking only masks the output; pos_r keeps its phase underneath
  always_comb begin
    bus.pos_o     = blank_q ? 3'd6 : pos_r;
    bus.tick_o    = tick_r;
    bus.running_o = (state == RUN);
  end

endmodule

// File: tb/tb_spin_ctrl.sv
// Randomized and directed bench for spin_ctrl with a queue-based scoreboard.
// Latency: expected outputs are pushed per edge and popped 1 time unit after it.
// Backpressure: none; the monitor compares every cycle.
module tb_spin_ctrl;
  localparam int BASE = 16;

  logic clk;
  logic rst;
  spin_ctrl_if bus ();

  spin_ctrl #(.BASE_DIV(BASE), .DIV_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] pos;
    logic       tick;
    logic       run;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   dut_ticks = 0;
  int   cyc_no = 0;

  // Behavioural model: elapsed-time counter against a latched period
  bit m_run, m_prev_step, m_blank, m_tick;
  int m_pos, m_elapsed, m_period, m_ticks;

  // Current stimulus values
  bit c_rst, c_en, c_dir, c_step, c_blank;
  int c_spd;

  task automatic m_advance(input bit d);
    m_pos  = d ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
    m_tick = 1'b1;
    m_ticks++;
  endtask

  task automatic model_edge();
    exp_t e;
    if (c_rst) begin
      m_run = 0; m_pos = 0; m_elapsed = 0; m_period = 0;
      m_prev_step = 1; m_blank = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (!m_run) begin
        if (c_en) begin
          m_run = 1; m_period = BASE >> c_spd; m_elapsed = 0;
        end else if (c_step && !m_prev_step) begin
          m_advance(c_dir);
        end
      end else if (!c_en) begin
        m_run = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed >= m_period) begin
          m_advance(c_dir);
          m_period  = BASE >> c_spd;
          m_elapsed = 0;
        end
      end
      m_prev_step = c_step;
      m_blank     = c_blank;
    end
    e.pos  = m_blank ? 3'd6 : 3'(m_pos);
    e.tick = m_tick;
    e.run  = m_run;
    exp_q.push_back(e);
  endtask

  // Apply current stimulus for the next edge, record expectation, move on
  task automatic cycle();
    rst         = c_rst;
    bus.en_i    = c_en;
    bus.dir_i   = c_dir;
    bus.speed_i = 2'(c_spd);
    bus.step_i  = c_step;
    bus.blank_i = c_blank;
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_n(input int n);
    repeat (n) cycle();
  endtask

  // Monitor: pop one expectation per edge and compare all outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (bus.tick_o === 1'b1) dut_ticks++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.pos_o !== e.pos || bus.tick_o !== e.tick || bus.running_o !== e.run) begin
          errors++;
          if (errors <= 30)
            $display("FAIL outputs cycle %0d: pos_o=%0d tick_o=%b running_o=%b, expected pos=%0d tick=%b running=%b",
                     cyc_no, bus.pos_o, bus.tick_o, bus.running_o, e.pos, e.tick, e.run);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    c_rst = 1; c_en = 0; c_dir = 0; c_spd = 0; c_step = 1; c_blank = 0;

    // Reset with the button held; no step after release until a fresh edge
    run_n(3);
    c_rst = 0;
    run_n(5);
    c_step = 0; run_n(2);
    c_step = 1; run_n(3);
    c_step = 0; run_n(1);

    // Back to pos 0, then forward run at full period
    c_rst = 1; run_n(2); c_rst = 0; c_step = 0; run_n(2);
    c_en = 1; run_n(100);

    // Reverse at speed 2, switch to speed 3 partway through an interval
    c_en = 0; run_n(2);
    c_dir = 1; c_spd = 2; c_en = 1; run_n(2);
    c_spd = 3; run_n(30);

    // Stop and step to position 5
    c_en = 0; c_dir = 0; run_n(2);
    for (int k = 0; k < 12 && m_pos != 5; k++) begin
      c_step = 1; run_n(1); c_step = 0; run_n(2);
    end
    // Three pulses of 1, 5 and 20 cycles
    c_step = 1; run_n(1);  c_step = 0; run_n(3);
    c_step = 1; run_n(5);  c_step = 0; run_n(3);
    c_step = 1; run_n(20); c_step = 0; run_n(3);

    // Step pulses while running must not add advances
    c_spd = 0; c_en = 1;
    for (int k = 0; k < 4; k++) begin
      c_step = 1; run_n(3); c_step = 0; run_n(4);
    end

    // Drop enable exactly on the expiring-count edge, then re-enable
    for (int k = 0; k < 40 && !(m_run && m_elapsed == m_period - 1); k++) run_n(1);
    c_en = 0; run_n(3);
    c_en = 1; run_n(40);

    // Blank for 40 cycles while running at period 16
    c_blank = 1; run_n(40);
    c_blank = 0; run_n(10);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      c_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) c_en = ~c_en;
      if ($urandom_range(0, 3) == 0)  c_step = ~c_step;
      if ($urandom_range(0, 29) == 0) c_blank = ~c_blank;
      if ($urandom_range(0, 19) == 0) c_spd = $urandom_range(0, 3);
      c_dir = $urandom_range(0, 1);
      cycle();
    end
    c_rst = 0;

    // Drain the scoreboard and reconcile totals
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    checks++;
    if (dut_ticks != m_ticks) begin
      errors++;
      $display("FAIL tick_total: dut ticks=%0d, expected %0d", dut_ticks, m_ticks);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spin_ctrl.md
# spin_ctrl

Sequencer for the LED-spinner datapath: generates the 3-bit segment position that feeds the seven-segment decoder (positions 0..5 = segments A..F, 6 = all off). Contains a programmable prescaler, a run/stop state machine, direction and speed control, single-step on button edge, and a blanking override. Sits between the board inputs (switches and debounced buttons) and the segment decoder.

## Interface
- `BASE_DIV`, default 24'd6_000_000: step period in clock cycles at speed 0. Must be ≥ 8.
- `DIV_W`, default 24: prescaler counter width. Must hold `BASE_DIV`−1.
- `clk_i` in 1: single clock; all state updates on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `en_i` in 1: 1 = run, 0 = stop (position frozen).
- `dir_i` in 1: 0 = forward (0→1→…→5→0), 1 = reverse (0→5→4→…→0).
- `speed_i` in 2: period select; period = `BASE_DIV >> speed_i` cycles.
- `step_i` in 1: level from a debounced button; each rising edge advances one position while stopped.
- `blank_i` in 1: 1 = force display off.
- `pos_o` out 3: position to the segment decoder; 0..5, or 6 when blanked.
- `tick_o` out 1: one-cycle pulse on every position advance.
- `running_o` out 1: 1 while FSM is in RUN.

## Operation
- Registers: `state` (STOP/RUN), `cnt[DIV_W-1:0]`, `pos_r[2:0]`, `step_q`, `blank_q`.
- Advance function: forward gives `pos_r==5 ? 0 : pos_r+1`; reverse gives `pos_r==0 ? 5 : pos_r-1`. `dir_i` is sampled on the advancing edge. `pos_r` never takes 6 or 7.
- STOP state:
  - If `en_i=1`: go to RUN and load `cnt = (BASE_DIV>>speed_i)-1`. `step_i` is ignored on this edge.
  - Otherwise, if `step_i=1` and `step_q=0`: advance `pos_r` and pulse `tick_o`. `cnt` holds.
- RUN state:
  - If `en_i=0`: go to STOP. No advance, even if `cnt==0` on the same edge.
  - Otherwise, if `cnt==0`: advance `pos_r`, pulse `tick_o`, reload `cnt` from the current `speed_i`.
  - Otherwise: decrement `cnt`.
  - Step edges are ignored in RUN.
- `step_q <= step_i` every cycle.
- `blank_q <= blank_i` every cycle. `pos_o = blank_q ? 3'd6 : pos_r`.
- `pos_r` keeps advancing while blanked, so the spinner resumes at the correct phase.
- A speed change takes effect at the next reload only; the count in progress completes at the old period.
- Arithmetic: `BASE_DIV>>speed_i` truncates. With `BASE_DIV ≥ 8` the period is always ≥ 1. A period of 1 means an advance on every RUN cycle (`cnt` reloads to 0).

## Timing
- Reset values: state=STOP, `cnt=0`, `pos_r=0`, `blank_q=0`, `step_q=1`.
  - `pos_o=0`, `tick_o=0`, `running_o=0`.
  - `step_q=1` ensures a button held through reset produces no step.
- Reset asserted mid-operation overrides everything on that edge and returns all registers to the reset values.
- Start latency: `en_i` sampled high at edge E0 gives RUN with `cnt=P-1` after E0. The first advance is at edge E0+P; subsequent advances every P cycles.
- `tick_o` is registered and high for exactly the cycle following each advancing edge, aligned with the new `pos_o`.
- `running_o` is registered and high in the cycle after E0; it drops in the cycle after the stopping edge.
- Step latency: `pos_o` changes in the cycle after the edge that sees `step_i` high with `step_q` low. One advance per rising edge, regardless of high duration.
- Blank latency: 1 cycle from `blank_i` to `pos_o`.

## Test plan
- Reset with `step_i=1` held, then release reset → `pos_o=0`, `tick_o=0`, `running_o=0`, no step until `step_i` falls and rises again.
- `BASE_DIV=16`, `speed_i=0`, `dir_i=0`, `en_i=1` at E0 → `pos_o` steps 1,2,3,4,5,0 at E0+16, +32, …, +96; one `tick_o` per step.
- `BASE_DIV=16`, `speed_i=2`, `dir_i=1`, started from `pos=0` → period 4; `pos_o` goes 5,4,3,2,1,0,5. Change `speed_i` to 3 mid-count → the current interval stays 4, following intervals are 2.
- Stopped at `pos=5`, `dir_i=0`, three `step_i` pulses of 1, 5 and 20 cycles → `pos_o` goes 0,1,2 with exactly three ticks. `step_i` pulses while `en_i=1` → no extra advances.
- `en_i` dropped on the same edge as `cnt==0` → no advance, `running_o=0` next cycle. Re-enable → first advance a full period later.
- `blank_i=1` for 40 cycles while running at period 16 → `pos_o=6` from the next cycle. On release, `pos_o` shows the position advanced by 2 or 3 steps as counted by ticks.
